// File: rtl/knn_pkg.sv
// Shared definitions for the kNN distance sequencer: ALU opcodes, FSM state
// encoding, float constants and the training-row address helper.
package knn_pkg;

    localparam logic [3:0] OP_SUBMUL = 4'b0000;
    localparam logic [3:0] OP_FADD   = 4'b0001;
    localparam logic [3:0] OP_FSQRT  = 4'b0010;
    localparam logic [3:0] OP_MLTFM  = 4'b0011;
    localparam logic [3:0] OP_MSTFM  = 4'b0100;
    localparam logic [3:0] OP_MKTFM  = 4'b0101;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_TEST,
        S_FETCH,
        S_SUBMUL,
        S_ACC,
        S_LBL_FETCH,
        S_SQRT,
        S_INSERT,
        S_SORT,
        S_VOTE,
        S_DONE
    } state_e;

    // First word of training row `row`: the test vector occupies 0..nf-1,
    // then each row is nf features followed by its label word.
    function automatic logic [31:0] row_base(input int unsigned nf, input logic [9:0] row);
        return nf + 32'(row) * (nf + 32'd1);
    endfunction

endpackage

// File: rtl/knn_test_vec_rf.sv
// Test-vector register file: one write port, one combinational read port,
// asynchronous active-low clear. Storage is rounded up to 2**AW entries so
// every read index is in range; entries at or above DEPTH are never written.
module knn_test_vec_rf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] regs_q [2**AW];

    // Write port; unused upper entries stay at their cleared value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2**AW; i++) regs_q[i] <= '0;
        end else if (we_i && (32'(waddr_i) < DEPTH)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/knn_dist_sequencer.sv
// kNN distance-loop sequencer: loads the test vector, then per training row
// issues SUBMUL/FADD per feature, FSQRT, and an MLTFM insert; finally MSTFM
// and MKTFM to obtain the predicted class. ALU operands are driven
// combinationally from state because operands (mem_rdata) and the ALU
// result are only valid in the command cycle itself.
module knn_dist_sequencer
    import knn_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = 4,
    parameter int unsigned NUM_ROWS     = 1,
    parameter int unsigned K            = 1,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              alu_en_o,
    output logic [3:0]        alu_control_o,
    output logic [31:0]       alu_in1_o,
    output logic [31:0]       alu_in2_o,
    output logic [9:0]        alu_cnt_o,
    input  logic [31:0]       alu_result_i,
    output logic [31:0]       dist_out_o,
    output logic              dist_valid_o,
    output logic [3:0]        class_out_o
);

    // f must also count one past the last feature during LD_TEST.
    localparam int unsigned FW     = $clog2(NUM_FEATURES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FEATURES - 1);
    localparam logic [FW-1:0] F_END  = FW'(NUM_FEATURES);
    localparam logic [9:0]    R_LAST = 10'(NUM_ROWS - 1);
    localparam logic [9:0]    R_CNT  = 10'(NUM_ROWS);

    // K only matters to the top-k unit; a zero value is a build error there.
    if (K == 0) begin : g_k_zero
    end

    state_e        state_q;
    logic [FW-1:0] f_q;
    logic [9:0]    r_q;
    logic [31:0]   acc_q;
    logic [31:0]   sq_q;
    logic [31:0]   dist_q;
    logic [3:0]    label_q;
    logic [3:0]    class_q;
    logic          busy_q;
    logic          done_q;
    logic          dist_valid_q;

    logic          test_we;
    logic [31:0]   test_rd;
    logic [31:0]   base_addr;

    // Read data for address f-1 lands while f points one word ahead.
    assign test_we   = (state_q == S_LD_TEST) && (f_q != '0);
    assign base_addr = row_base(NUM_FEATURES, r_q);

    knn_test_vec_rf #(
        .DEPTH (NUM_FEATURES),
        .AW    (FW)
    ) u_test_rf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (test_we),
        .waddr_i (f_q - FW'(1)),
        .wdata_i (mem_rdata_i),
        .raddr_i (f_q),
        .rdata_o (test_rd)
    );

    // Memory read strobe and address decode.
    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_addr_o  = '0;
        case (state_q)
            S_LD_TEST: begin
                if (f_q != F_END) begin
                    mem_rd_en_o = 1'b1;
                    mem_addr_o  = ADDR_W'(f_q);
                end
            end
            S_FETCH: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = ADDR_W'(base_addr + 32'(f_q));
            end
            S_LBL_FETCH: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = ADDR_W'(base_addr + NUM_FEATURES);
            end
            default: ;
        endcase
    end

    // ALU command bus; all zero outside the command states.
    always_comb begin
        alu_en_o      = 1'b0;
        alu_control_o = 4'b0000;
        alu_in1_o     = '0;
        alu_in2_o     = '0;
        alu_cnt_o     = '0;
        case (state_q)
            S_SUBMUL: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_SUBMUL;
                alu_in1_o     = test_rd;
                alu_in2_o     = mem_rdata_i;
            end
            S_ACC: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_FADD;
                alu_in1_o     = acc_q;
                alu_in2_o     = sq_q;
            end
            S_SQRT: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_FSQRT;
                alu_in1_o     = acc_q;
            end
            S_INSERT: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_MLTFM;
                alu_in1_o     = dist_q;
                alu_in2_o     = {28'b0, label_q};
                alu_cnt_o     = r_q;
            end
            S_SORT: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_MSTFM;
                alu_cnt_o     = R_CNT;
            end
            S_VOTE: begin
                alu_en_o      = 1'b1;
                alu_control_o = OP_MKTFM;
                alu_cnt_o     = R_CNT;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with its counters, datapath registers and status outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            f_q          <= '0;
            r_q          <= '0;
            acc_q        <= FP_ZERO;
            sq_q         <= '0;
            dist_q       <= '0;
            label_q      <= '0;
            class_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dist_valid_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            dist_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LD_TEST;
                        f_q     <= '0;
                        r_q     <= '0;
                        acc_q   <= FP_ZERO;
                        busy_q  <= 1'b1;
                    end
                end
                S_LD_TEST: begin
                    if (f_q == F_END) begin
                        f_q     <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        f_q <= f_q + FW'(1);
                    end
                end
                S_FETCH:  state_q <= S_SUBMUL;
                S_SUBMUL: begin
                    sq_q    <= alu_result_i;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    acc_q <= alu_result_i;
                    if (f_q == F_LAST) begin
                        state_q <= S_LBL_FETCH;
                    end else begin
                        f_q     <= f_q + FW'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_LBL_FETCH: state_q <= S_SQRT;
                S_SQRT: begin
                    dist_q       <= alu_result_i;
                    label_q      <= mem_rdata_i[3:0];
                    dist_valid_q <= 1'b1;
                    state_q      <= S_INSERT;
                end
                S_INSERT: begin
                    acc_q <= FP_ZERO;
                    f_q   <= '0;
                    if (r_q == R_LAST) begin
                        state_q <= S_SORT;
                    end else begin
                        r_q     <= r_q + 10'd1;
                        state_q <= S_FETCH;
                    end
                end
                S_SORT: state_q <= S_VOTE;
                S_VOTE: begin
                    class_q <= alu_result_i[3:0];
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign dist_out_o   = dist_q;
    assign dist_valid_o = dist_valid_q;
    assign class_out_o  = class_q;

endmodule
